tdd_frame_ctrl: RTL and testbench

TDD_FRAME_CTRL -- requirements
Module: tdd_frame_ctrl

---
 rtl/r7ocm_pkg.sv | 14 +
 rtl/win_cmp.sv | 17 +
 rtl/tdd_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_tdd_frame_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r7ocm_pkg.sv
// Shared definitions for the TDD frame controller: default counter width
// and the frame state encoding.
package r7ocm_pkg;

    // Default width of the sample counter and every timing input.
    localparam int CNT_W_DEFAULT = 24;

    // Frame timing states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : r7ocm_pkg

// File: rtl/win_cmp.sv
// Half-open window decoder: hit is high when start_pt <= cnt < end_pt.
// A window with start_pt >= end_pt never hits, and nothing wraps around.
module win_cmp #(
    parameter int W = 24
) (
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] start_pt,
    input  logic [W-1:0] end_pt,
    output logic         hit
);

    // Pure combinational compare; the caller registers the result.
    always_comb begin
        hit = (cnt >= start_pt) && (cnt < end_pt);
    end

endmodule : win_cmp

// File: rtl/tdd_frame_ctrl.sv
// TDD frame timing controller.
// Counts samples within a frame, pulses sync on sample 0, and opens the
// receive (Ien) and transmit (Oen) windows from shadowed timing inputs.
// Timing inputs are captured only on entry to RUN and at each frame wrap,
// so the frame in progress is never disturbed.
//
// Adjustment handshake: adj_req is a single-cycle request with no ready
// back-channel. A request is always accepted; adj_pending shows that an
// accepted request has not yet been applied. It is applied at the next wrap
// (one frame only) and further requests while pending are absorbed.
// A request arriving in the wrap cycle itself is applied to the next frame
// directly and never shows up on adj_pending.
module tdd_frame_ctrl
    import r7ocm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             Sclk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] frame_len,
    input  logic [CNT_W-1:0] frame_adj,
    input  logic             adj_req,
    input  logic [CNT_W-1:0] tstart,
    input  logic [CNT_W-1:0] tend,
    input  logic [CNT_W-1:0] rstart,
    input  logic [CNT_W-1:0] rend,
    output logic             Ien,
    output logic             Oen,
    output logic             sync,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [31:0]      frame_cnt,
    output logic             adj_pending,
    output state_t           dbg_state
);

    localparam logic signed [CNT_W+1:0] LEN_MIN = (CNT_W+2)'(2);
    localparam logic signed [CNT_W+1:0] LEN_MAX = $signed({2'b00, {CNT_W{1'b1}}});

    state_t state, state_nxt;
    logic [1:0] rst_sync;
    logic run_ok;

    logic [CNT_W-1:0] sh_len, sh_adj, sh_ts, sh_te, sh_rs, sh_re;
    logic [CNT_W-1:0] sh_len_nxt, sh_adj_nxt, sh_ts_nxt, sh_te_nxt, sh_rs_nxt, sh_re_nxt;
    logic adj_active, adj_active_nxt;
    logic pend_nxt;
    logic load;
    logic wrap;
    logic sync_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [31:0] fcnt_nxt;
    logic signed [CNT_W+1:0] len_sum;
    logic [CNT_W-1:0] eff_len;
    logic r_hit, t_hit;

    assign run_ok    = rst_sync[1];
    assign dbg_state = state;

    // Two-stage synchroniser: reset asserts asynchronously, releases on Sclk.
    always_ff @(posedge Sclk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    // Effective length of the current frame, optionally adjusted, clamped to [2, max].
    always_comb begin
        len_sum = $signed({2'b00, sh_len});
        if (adj_active) len_sum = len_sum + $signed({{2{sh_adj[CNT_W-1]}}, sh_adj});
        if (len_sum < LEN_MIN)      eff_len = CNT_W'(2);
        else if (len_sum > LEN_MAX) eff_len = '1;
        else                        eff_len = len_sum[CNT_W-1:0];
    end

    // Next-state, counters and adjustment bookkeeping.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = sample_cnt;
        fcnt_nxt       = frame_cnt;
        pend_nxt       = adj_pending | adj_req;
        adj_active_nxt = adj_active;
        load           = 1'b0;
        sync_nxt       = 1'b0;
        wrap           = (state == ST_RUN) && (sample_cnt == eff_len - CNT_W'(1));
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (enable && run_ok) begin
                    state_nxt      = ST_RUN;
                    load           = 1'b1;
                    adj_active_nxt = 1'b0;
                    sync_nxt       = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_nxt      = ST_IDLE;
                    cnt_nxt        = '0;
                    adj_active_nxt = 1'b0;
                end else if (wrap) begin
                    cnt_nxt        = '0;
                    fcnt_nxt       = frame_cnt + 32'd1;
                    load           = 1'b1;
                    adj_active_nxt = adj_pending | adj_req;
                    pend_nxt       = 1'b0;
                    sync_nxt       = 1'b1;
                end else begin
                    cnt_nxt = sample_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Shadow values as they will be after this edge.
    always_comb begin
        sh_len_nxt = load ? frame_len : sh_len;
        sh_adj_nxt = load ? frame_adj : sh_adj;
        sh_ts_nxt  = load ? tstart    : sh_ts;
        sh_te_nxt  = load ? tend      : sh_te;
        sh_rs_nxt  = load ? rstart    : sh_rs;
        sh_re_nxt  = load ? rend      : sh_re;
    end

    // Windows decode the next count against the next shadows so that the
    // registered enables line up with sample_cnt on the same edge.
    win_cmp #(.W(CNT_W)) u_rx_win (
        .cnt      (cnt_nxt),
        .start_pt (sh_rs_nxt),
        .end_pt   (sh_re_nxt),
        .hit      (r_hit)
    );

    win_cmp #(.W(CNT_W)) u_tx_win (
        .cnt      (cnt_nxt),
        .start_pt (sh_ts_nxt),
        .end_pt   (sh_te_nxt),
        .hit      (t_hit)
    );

    // State, counters, shadows and registered outputs.
    always_ff @(posedge Sclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sample_cnt  <= '0;
            frame_cnt   <= '0;
            adj_pending <= 1'b0;
            adj_active  <= 1'b0;
            sync        <= 1'b0;
            Ien         <= 1'b0;
            Oen         <= 1'b0;
            sh_len      <= '0;
            sh_adj      <= '0;
            sh_ts       <= '0;
            sh_te       <= '0;
            sh_rs       <= '0;
            sh_re       <= '0;
        end else begin
            state       <= state_nxt;
            sample_cnt  <= cnt_nxt;
            frame_cnt   <= fcnt_nxt;
            adj_pending <= pend_nxt;
            adj_active  <= adj_active_nxt;
            sync        <= sync_nxt;
            Ien         <= (state_nxt == ST_RUN) && r_hit;
            Oen         <= (state_nxt == ST_RUN) && t_hit;
            sh_len      <= sh_len_nxt;
            sh_adj      <= sh_adj_nxt;
            sh_ts       <= sh_ts_nxt;
            sh_te       <= sh_te_nxt;
            sh_rs       <= sh_rs_nxt;
            sh_re       <= sh_re_nxt;
        end
    end

endmodule : tdd_frame_ctrl

// File: tb/tb_tdd_frame_ctrl.sv
// Bench for tdd_frame_ctrl: directed scenarios plus random traffic, checked
// every cycle against a frame-level reference model.
module tb_tdd_frame_ctrl;
    import r7ocm_pkg::*;

    localparam int CNT_W = 24;
    localparam int EW = 5 + CNT_W + 32;
    localparam longint MAXV = (longint'(1) << CNT_W) - 1;

    logic             Sclk;
    logic             rst_n;
    logic             enable;
    logic [CNT_W-1:0] frame_len, frame_adj, tstart, tend, rstart, rend;
    logic             adj_req;
    logic             Ien, Oen, sync, adj_pending;
    logic [CNT_W-1:0] sample_cnt;
    logic [31:0]      frame_cnt;
    state_t           dbg_state;

    int n_checks = 0;
    int n_bad = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model state (frame-level view).
    bit          m_run;
    longint      m_pos, m_len;
    bit          m_sync, m_pend;
    logic [31:0] m_fcnt;
    longint      m_rs, m_re, m_ts, m_te;
    int          m_rel;

    tdd_frame_ctrl #(.CNT_W(CNT_W)) dut (
        .Sclk        (Sclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_len   (frame_len),
        .frame_adj   (frame_adj),
        .adj_req     (adj_req),
        .tstart      (tstart),
        .tend        (tend),
        .rstart      (rstart),
        .rend        (rend),
        .Ien         (Ien),
        .Oen         (Oen),
        .sync        (sync),
        .sample_cnt  (sample_cnt),
        .frame_cnt   (frame_cnt),
        .adj_pending (adj_pending),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog.
    initial begin
        Sclk = 1'b0;
        forever #5 Sclk = ~Sclk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame length from the rules: length plus optional signed adjustment, clamped.
    function automatic longint frame_length(input logic [CNT_W-1:0] fl,
                                            input logic [CNT_W-1:0] adj,
                                            input bit use_adj);
        longint v;
        v = longint'(fl);
        if (use_adj) v = v + longint'($signed(adj));
        if (v < 2) v = 2;
        if (v > MAXV) v = MAXV;
        return v;
    endfunction

    task automatic model_latch(input bit use_adj);
        m_len = frame_length(frame_len, frame_adj, use_adj);
        m_rs = longint'(rstart);
        m_re = longint'(rend);
        m_ts = longint'(tstart);
        m_te = longint'(tend);
    endtask

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_len = 2; m_sync = 0; m_pend = 0; m_fcnt = '0;
        m_rs = 0; m_re = 0; m_ts = 0; m_te = 0; m_rel = 0;
        exp_q.delete();
    endtask

    task automatic model_push();
        bit ien, oen;
        ien = m_run && (m_pos >= m_rs) && (m_pos < m_re);
        oen = m_run && (m_pos >= m_ts) && (m_pos < m_te);
        exp_q.push_back({ien, oen, m_sync, m_pend, m_run, CNT_W'(m_pos), m_fcnt});
    endtask

    // One sample-clock step of the reference model, using pre-edge inputs.
    task automatic model_step();
        bit allow;
        if (!rst_n) begin
            model_reset();
        end else begin
            allow = (m_rel >= 2);
            if (m_rel < 100) m_rel++;
            if (!enable) begin
                m_run = 0; m_pos = 0; m_sync = 0;
                m_pend = m_pend | adj_req;
            end else if (!m_run) begin
                if (allow) begin
                    m_run = 1; m_pos = 0; m_sync = 1;
                    model_latch(1'b0);
                end else begin
                    m_sync = 0;
                end
                m_pend = m_pend | adj_req;
            end else if (m_pos == m_len - 1) begin
                model_latch(m_pend | adj_req);
                m_pos = 0; m_sync = 1; m_pend = 0;
                m_fcnt = m_fcnt + 32'd1;
            end else begin
                m_pos++; m_sync = 0;
                m_pend = m_pend | adj_req;
            end
        end
        model_push();
    endtask

    always @(posedge Sclk) model_step();

    // Advance one cycle and compare the DUT against the model on the falling edge.
    task automatic cycle();
        logic [EW-1:0] e;
        @(negedge Sclk);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_bad++;
            $display("FAIL exp_q: got=empty exp=entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check_eq("Ien", 64'(Ien), 64'(e[EW-1]));
            check_eq("Oen", 64'(Oen), 64'(e[EW-2]));
            check_eq("sync", 64'(sync), 64'(e[EW-3]));
            check_eq("adj_pending", 64'(adj_pending), 64'(e[EW-4]));
            check_eq("state", 64'(dbg_state), 64'(e[EW-5]));
            check_eq("sample_cnt", 64'(sample_cnt), 64'(e[CNT_W+31:32]));
            check_eq("frame_cnt", 64'(frame_cnt), 64'(e[31:0]));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pos(input longint p);
        for (int g = 0; g < 200 && !(m_run && m_pos == p); g++) cycle();
        if (!(m_run && m_pos == p)) begin
            n_checks++;
            n_bad++;
            $display("FAIL wait_pos: got=%0d exp=%0d", m_pos, p);
        end
    endtask

    task automatic pulse_adj(input logic [CNT_W-1:0] adj);
        frame_adj = adj;
        adj_req = 1'b1;
        cycle();
        adj_req = 1'b0;
    endtask

    task automatic set_timing(input int fl, input int rs, input int re, input int ts, input int te);
        frame_len = CNT_W'(fl);
        rstart = CNT_W'(rs); rend = CNT_W'(re);
        tstart = CNT_W'(ts); tend = CNT_W'(te);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_fcnt", 64'(frame_cnt), 64'(m_fcnt));
        check_eq("async_pend", 64'(adj_pending), 64'(m_pend));
        check_eq("async_cnt", 64'(sample_cnt), 64'(m_pos));
        check_eq("async_ien_oen", 64'({Ien, Oen, sync}), 64'(0));
        run(3);
        rst_n = 1'b1;
    endtask

    // Stimulus.
    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        adj_req = 1'b0;
        frame_adj = '0;
        set_timing(10, 2, 5, 6, 9);
        model_reset();
        run(3);
        rst_n = 1'b1;
        enable = 1'b1;

        // Basic frame: windows and frame counting.
        run(45);

        // Shortening one frame by 3, requested mid-frame.
        wait_pos(4);
        pulse_adj(-CNT_W'(3));
        run(30);

        // Length change mid-frame only affects the next frame.
        wait_pos(5);
        frame_len = CNT_W'(20);
        run(45);

        // Minimum length clamp, plain and through adjustment.
        frame_len = CNT_W'(1);
        run(12);
        frame_len = CNT_W'(5);
        pulse_adj(-CNT_W'(10));
        run(12);

        // Empty receive window and transmit window running past the wrap.
        set_timing(10, 5, 5, 6, 50);
        run(30);

        // Request landing on the wrap cycle, then a second request absorbed.
        wait_pos(9);
        pulse_adj(CNT_W'(4));
        pulse_adj(CNT_W'(2));
        run(5);
        pulse_adj(CNT_W'(3));
        run(30);

        // Enable drop mid-frame, pending retained across IDLE.
        wait_pos(6);
        enable = 1'b0;
        run(2);
        pulse_adj(-CNT_W'(2));
        run(2);
        enable = 1'b1;
        run(25);

        // Asynchronous reset mid-frame, then resync.
        wait_pos(3);
        async_reset();
        run(20);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) frame_len = CNT_W'($urandom_range(0, 16));
            if ($urandom_range(0, 9) == 0) begin
                rstart = CNT_W'($urandom_range(0, 18)); rend = CNT_W'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 9) == 0) begin
                tstart = CNT_W'($urandom_range(0, 18)); tend = CNT_W'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 7) == 0) frame_adj = CNT_W'($urandom_range(0, 16)) - CNT_W'(8);
            adj_req = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 199) == 0) begin
                adj_req = 1'b0;
                async_reset();
            end
            cycle();
        end
        adj_req = 1'b0;
        enable = 1'b1;
        run(10);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_tdd_frame_ctrl
